// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris move scheduler.
// Command codes, FSM encoding and the gravity period helper.
package tetris_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;
  localparam logic [2:0] CMD_GRAV  = 3'd5;
  localparam logic [2:0] CMD_DROP  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HALT
  } state_e;

  function automatic int grav_period(
    input int lvl,
    input int base,
    input int step,
    input int min_p
  );
    int p;
    p = base - lvl * step;
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Per-button edge detect with optional auto-repeat.
// Emits a one-cycle fire on press and on each repeat interval.
module key_repeat #(
  parameter int DELAY  = 20,
  parameter int RATE   = 5,
  parameter bit REPEAT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pause,
  input  logic freeze,
  input  logic btn,
  output logic fire
);

  localparam int CMAX = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LD_DELAY = CW'(DELAY);
  localparam logic [CW-1:0] LD_RATE  = CW'(RATE);

  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise, rep;

  // Count held ticks; first repeat after DELAY, then every RATE.
  always_comb begin
    cnt_d = cnt_q;
    rep   = 1'b0;
    rise  = btn & ~prev_q;
    if (freeze) begin
      cnt_d = cnt_q;
    end else if (!btn || rise) begin
      cnt_d = LD_DELAY;
    end else if (tick) begin
      if (cnt_q <= CW'(1)) begin
        rep   = REPEAT;
        cnt_d = LD_RATE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  assign fire = !freeze && !pause && (rise || rep);

  // Previous-button and repeat counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
      cnt_q  <= LD_DELAY;
    end else begin
      prev_q <= btn;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Tetris move scheduler: buttons and gravity to one command
// at a time over valid/ready, with score-driven level.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5,
  parameter int GRAV_BASE    = 100,
  parameter int GRAV_STEP    = 6,
  parameter int GRAV_MIN     = 10,
  parameter int LEVEL_POINTS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        pause,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_down,
  input  logic        btn_drop,
  input  logic [13:0] score,
  input  logic        gameover,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  input  logic        cmd_ready,
  output logic [3:0]  level
);

  localparam int GW = 16;
  localparam int TW = 15;

  state_e          state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [6:0]      flags_q, flags_d;
  logic [6:0]      key_set, set_v, clr;
  logic [GW-1:0]   grav_q, grav_d, grav_ld;
  logic [3:0]      level_q, level_d;
  logic [TW-1:0]   thr_q, thr_d;
  logic [2:0]      pick;
  logic            halt, grav_fire;
  logic            f_l, f_r, f_rot, f_dn, f_drop;

  assign halt = (state_q == ST_HALT);

  key_repeat #(REPEAT_DELAY, REPEAT_RATE, 1'b1) u_left (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .freeze(halt), .btn(btn_left), .fire(f_l));
  key_repeat #(REPEAT_DELAY, REPEAT_RATE, 1'b1) u_right (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .freeze(halt), .btn(btn_right), .fire(f_r));
  key_repeat #(REPEAT_DELAY, REPEAT_RATE, 1'b0) u_rot (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .freeze(halt), .btn(btn_rotate), .fire(f_rot));
  key_repeat #(REPEAT_DELAY, REPEAT_RATE, 1'b1) u_down (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .freeze(halt), .btn(btn_down), .fire(f_dn));
  key_repeat #(REPEAT_DELAY, REPEAT_RATE, 1'b0) u_drop (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .freeze(halt), .btn(btn_drop), .fire(f_drop));

  assign key_set = {f_drop, 1'b0, f_dn, f_rot, f_r, f_l, 1'b0};

  assign grav_ld = GW'(grav_period(int'(level_q), GRAV_BASE,
                                   GRAV_STEP, GRAV_MIN));

  // Highest-priority pending command.
  always_comb begin
    pick = CMD_NONE;
    priority case (1'b1)
      flags_q[CMD_DROP]:  pick = CMD_DROP;
      flags_q[CMD_GRAV]:  pick = CMD_GRAV;
      flags_q[CMD_ROT]:   pick = CMD_ROT;
      flags_q[CMD_LEFT]:  pick = CMD_LEFT;
      flags_q[CMD_RIGHT]: pick = CMD_RIGHT;
      flags_q[CMD_DOWN]:  pick = CMD_DOWN;
      default:            pick = CMD_NONE;
    endcase
  end

  // Gravity countdown, flag update and issue FSM next state.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    grav_d    = grav_q;
    grav_fire = 1'b0;
    clr       = 7'd0;
    if (!halt && !pause && tick) begin
      if (grav_q <= GW'(1)) begin
        grav_fire = 1'b1;
        grav_d    = grav_ld;
      end else begin
        grav_d = grav_q - GW'(1);
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (!pause && pick != CMD_NONE) begin
          state_d = ST_ISSUE;
          cmd_d   = pick;
          clr     = 7'd1 << pick;
          if (pick == CMD_DROP) begin
            clr[CMD_GRAV] = 1'b1;
            grav_fire     = 1'b0;
            grav_d        = grav_ld;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
        end
      end
      default: begin
        state_d = ST_HALT;
        cmd_d   = CMD_NONE;
      end
    endcase
    if (gameover) begin
      state_d = ST_HALT;
      cmd_d   = CMD_NONE;
    end
    set_v           = key_set;
    set_v[CMD_GRAV] = grav_fire;
    if (gameover || halt) begin
      flags_d = 7'd0;
    end else begin
      flags_d = (flags_q & ~clr) | set_v;
    end
  end

  // Level steps once per cycle while score meets the threshold.
  always_comb begin
    level_d = level_q;
    thr_d   = thr_q;
    if ({1'b0, score} >= thr_q && level_q != 4'd15) begin
      level_d = level_q + 4'd1;
      thr_d   = thr_q + TW'(LEVEL_POINTS);
    end
  end

  // State, command, flag, gravity and level registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      flags_q <= 7'd0;
      grav_q  <= GW'(GRAV_BASE);
      level_q <= 4'd0;
      thr_q   <= TW'(LEVEL_POINTS);
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      flags_q <= flags_d;
      grav_q  <= grav_d;
      level_q <= level_d;
      thr_q   <= thr_d;
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign cmd       = cmd_q;
  assign level     = level_q;

endmodule
